// File: rtl/dds_dac_spi_sched_if.sv
// Bus bundle between the DDS sample sources and the DAC SPI scheduler.
// master: the DDS datapath and register-bank side. slave: the scheduler.
interface dds_dac_spi_sched_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 16
);
    logic              out_en;
    logic [NCH-1:0]    req_valid;
    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    req_ready;
    logic              cs_n;
    logic              sclk;
    logic              dout;
    logic              da_clr;
    logic              busy;
    logic              frame_done;

    modport master (
        output out_en, req_valid, req_data,
        input  req_ready, cs_n, sclk, dout, da_clr, busy, frame_done
    );

    modport slave (
        input  out_en, req_valid, req_data,
        output req_ready, cs_n, sclk, dout, da_clr, busy, frame_done
    );
endinterface

// File: rtl/dds_dac_spi_sched.sv
// Round-robin scheduler and SPI frame sequencer for the shared DDS DAC.
// Grants one sample source per frame and shifts {CMD, ADDR, DATA} out MSB first
// (CPOL=0, data changes on the falling edge, DAC samples on the rising edge).
// Optional build macro DDS_SCHED_CH0_PRIO_EN: channel 0 gets strict priority,
// channels 1..NCH-1 stay round-robin among themselves.
module dds_dac_spi_sched #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 2,
    parameter logic [3:0]  CMD     = 4'b0011
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,
    dds_dac_spi_sched_if.slave bus
);

`ifdef DDS_SCHED_CH0_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    localparam int unsigned PW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned FW   = 8 + DW;
    localparam int unsigned BW   = $clog2(FW);
    localparam int unsigned CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t          state, state_d;
    logic [PW-1:0]   rr_ptr, rr_ptr_d;
    logic [FW-1:0]   frame, frame_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [BW-1:0]   bit_cnt, bit_cnt_d;
    logic            tail, tail_d;
    logic [NCH-1:0]  ready_q, ready_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            dout_q, dout_d;
    logic            da_clr_q, da_clr_d;
    logic            busy_q, busy_d;
    logic            fd_q, fd_d;

    logic            found;
    logic [PW-1:0]   gnt, idx, ptr_nxt;
    logic            can_grant;
    int unsigned     sum;

    // Pick the first eligible requester at or after rr_ptr, wrapping modulo NCH.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        sum   = 0;
        if (PRIO && bus.req_valid[0]) begin
            found = 1'b1;
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            sum = int'(rr_ptr) + i;
            if (sum >= NCH) sum = sum - NCH;
            idx = PW'(sum);
            if (!found && !(PRIO && idx == '0) && bus.req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
        sum = int'(gnt) + 1;
        if (PRIO && gnt == '0)
            ptr_nxt = rr_ptr;
        else
            ptr_nxt = (sum >= NCH) ? '0 : PW'(sum);
        can_grant = bus.out_en && found;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d   = state;
        rr_ptr_d  = rr_ptr;
        frame_d   = frame;
        cnt_d     = cnt;
        bit_cnt_d = bit_cnt;
        tail_d    = tail;
        ready_d   = '0;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        dout_d    = dout_q;
        fd_d      = 1'b0;
        case (state)
            IDLE: begin
                if (can_grant) begin
                    state_d      = LOAD;
                    ready_d[gnt] = 1'b1;
                    frame_d      = {CMD, 4'(gnt), bus.req_data[int'(gnt)*DW +: DW]};
                    rr_ptr_d     = ptr_nxt;
                end
            end
            LOAD: begin
                state_d   = SHIFT;
                cs_n_d    = 1'b0;
                sclk_d    = 1'b0;
                dout_d    = frame[FW-1];
                frame_d   = frame << 1;
                cnt_d     = '0;
                bit_cnt_d = '0;
                tail_d    = 1'b0;
            end
            SHIFT: begin
                // One trailing sclk-low cycle after the last bit holds cs_n low.
                if (tail) begin
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                    sclk_d  = 1'b0;
                    dout_d  = 1'b0;
                    fd_d    = 1'b1;
                    cnt_d   = '0;
                end else if (cnt == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            tail_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt + 1'b1;
                            dout_d    = frame[FW-1];
                            frame_d   = frame << 1;
                        end
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                // Arbitration also runs on the last gap cycle so a pending request
                // goes straight to LOAD, giving a 1+(1+48*CLK_DIV)+CS_GAP period.
                if (cnt == GAP_LAST) begin
                    if (can_grant) begin
                        state_d      = LOAD;
                        ready_d[gnt] = 1'b1;
                        frame_d      = {CMD, 4'(gnt), bus.req_data[int'(gnt)*DW +: DW]};
                        rr_ptr_d     = ptr_nxt;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        if (bus.out_en)
            da_clr_d = 1'b0;
        else if (state_d == IDLE)
            da_clr_d = 1'b1;
        else
            da_clr_d = da_clr_q;
    end

    // State and output registers; reset returns the DAC pins to idle immediately.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            frame    <= '0;
            cnt      <= '0;
            bit_cnt  <= '0;
            tail     <= 1'b0;
            ready_q  <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            dout_q   <= 1'b0;
            da_clr_q <= 1'b1;
            busy_q   <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            frame    <= frame_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_cnt_d;
            tail     <= tail_d;
            ready_q  <= ready_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            dout_q   <= dout_d;
            da_clr_q <= da_clr_d;
            busy_q   <= busy_d;
            fd_q     <= fd_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.sclk       = sclk_q;
    assign bus.dout       = dout_q;
    assign bus.da_clr     = da_clr_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_dds_dac_spi_sched.sv
// Bench for dds_dac_spi_sched: a default instance (CLK_DIV=2, CS_GAP=2) and a
// fast instance (CLK_DIV=1, CS_GAP=1), observed pin-level and compared against
// a round-robin/priority scheduling model and frame contents built from the data.
module tb_dds_dac_spi_sched;

`ifdef DDS_SCHED_CH0_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dds_dac_spi_sched_if #(.NCH(4), .DW(16)) bus ();
    dds_dac_spi_sched_if #(.NCH(4), .DW(16)) fbus ();

    dds_dac_spi_sched #(.NCH(4), .DW(16), .CLK_DIV(2), .CS_GAP(2), .CMD(4'b0011)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .bus(bus));
    dds_dac_spi_sched #(.NCH(4), .DW(16), .CLK_DIV(1), .CS_GAP(1), .CMD(4'b0011)) dut_fast (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .bus(fbus));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int m_ptr = 0;
    logic [15:0] dat [4];

    // pin monitor state (default instance)
    logic prev_cs, prev_sclk;
    int low_run, nbits, fd_cnt;
    logic [23:0] shbits;
    int g_idx_q[$], g_cyc_q[$], low_q[$];
    logic [23:0] frm_q[$];
    // pin monitor state (fast instance)
    logic f_prev_cs, f_prev_sclk;
    int f_low_run, f_nr, f_first, f_last;
    int fg_cyc_q[$], f_low_q[$], f_nr_q[$], f_span_q[$];

    function automatic int onehot_idx(input logic [3:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int exp_grant(input logic [3:0] v, input int ptr);
        int c;
        if (PRIO && v[0]) return 0;
        for (int k = 0; k < 4; k++) begin
            c = (ptr + k) % 4;
            if (v[c] && !(PRIO && c == 0)) return c;
        end
        return -1;
    endfunction

    function automatic int exp_ptr(input int g, input int ptr);
        if (PRIO && g == 0) return ptr;
        return (g + 1) % 4;
    endfunction

    function automatic logic [23:0] exp_frame(input int g, input logic [15:0] d);
        return {4'h3, 4'(g), d};
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; low_run = 0; nbits = 0; shbits = '0;
            f_prev_cs = 1'b1; f_prev_sclk = 1'b0; f_low_run = 0; f_nr = 0;
            return;
        end
        if (bus.req_ready != '0) begin
            g_idx_q.push_back(onehot_idx(bus.req_ready));
            g_cyc_q.push_back(cyc);
        end
        if (bus.frame_done) fd_cnt++;
        if (!bus.cs_n && prev_cs) begin nbits = 0; shbits = '0; low_run = 0; end
        if (!bus.cs_n) low_run++;
        if (!bus.cs_n && bus.sclk && !prev_sclk) begin shbits = {shbits[22:0], bus.dout}; nbits++; end
        if (bus.cs_n && !prev_cs) begin low_q.push_back(low_run); frm_q.push_back(shbits); end
        prev_cs = bus.cs_n; prev_sclk = bus.sclk;

        if (fbus.req_ready != '0) fg_cyc_q.push_back(cyc);
        if (!fbus.cs_n && f_prev_cs) begin f_nr = 0; f_low_run = 0; end
        if (!fbus.cs_n) f_low_run++;
        if (!fbus.cs_n && fbus.sclk && !f_prev_sclk) begin
            if (f_nr == 0) f_first = cyc;
            f_last = cyc;
            f_nr++;
        end
        if (fbus.cs_n && !f_prev_cs) begin
            f_low_q.push_back(f_low_run); f_nr_q.push_back(f_nr); f_span_q.push_back(f_last - f_first);
        end
        f_prev_cs = fbus.cs_n; f_prev_sclk = fbus.sclk;
    endtask

    task automatic wait_grants(input int n, input int budget, output bit ok);
        ok = (g_idx_q.size() >= n);
        for (int i = 0; i < budget && !ok; i++) begin tick(); ok = (g_idx_q.size() >= n); end
    endtask

    task automatic wait_fgrants(input int n, input int budget, output bit ok);
        ok = (fg_cyc_q.size() >= n);
        for (int i = 0; i < budget && !ok; i++) begin tick(); ok = (fg_cyc_q.size() >= n); end
    endtask

    task automatic wait_fd(input int n, input int budget, output bit ok);
        ok = (fd_cnt >= n);
        for (int i = 0; i < budget && !ok; i++) begin tick(); ok = (fd_cnt >= n); end
    endtask

    task automatic wait_bits(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin tick(); ok = (nbits == n); end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin tick(); ok = (bus.busy === 1'b0); end
    endtask

    task automatic set_data();
        bus.req_data = {dat[3], dat[2], dat[1], dat[0]};
    endtask

    task automatic do_reset();
        bus.out_en = 1'b0; bus.req_valid = '0;
        fbus.out_en = 1'b0; fbus.req_valid = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        m_ptr = 0;
        g_idx_q.delete(); g_cyc_q.delete(); low_q.delete(); frm_q.delete();
        fg_cyc_q.delete(); f_low_q.delete(); f_nr_q.delete(); f_span_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.out_en = 1'b0; bus.req_valid = '0; bus.req_data = '0;
        fbus.out_en = 1'b0; fbus.req_valid = '0; fbus.req_data = '0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.req_ready, bus.cs_n, bus.sclk, bus.dout, bus.da_clr, bus.busy, bus.frame_done} !== 10'b0000_1_0_0_1_0_0) begin
            fails++;
            $display("FAIL reset_in: got %b want 0000100100",
                {bus.req_ready, bus.cs_n, bus.sclk, bus.dout, bus.da_clr, bus.busy, bus.frame_done});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        tests++;
        if ({bus.req_ready, bus.cs_n, bus.sclk, bus.dout, bus.da_clr, bus.busy, bus.frame_done} !== 10'b0000_1_0_0_1_0_0) begin
            fails++;
            $display("FAIL reset_out: got %b want 0000100100",
                {bus.req_ready, bus.cs_n, bus.sclk, bus.dout, bus.da_clr, bus.busy, bus.frame_done});
        end
    endtask

    task automatic test_single();
        bit ok;
        int fd0, g;
        do_reset();
        for (int i = 0; i < 4; i++) dat[i] = 16'($urandom);
        dat[2] = 16'hA5C3;
        set_data();
        fd0 = fd_cnt;
        bus.out_en = 1'b1; bus.req_valid = 4'b0100;
        wait_grants(1, 10, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL single_grant_timeout: got none want 1 grant"); return; end
        tests++;
        if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
        g = exp_grant(4'b0100, m_ptr);
        m_ptr = exp_ptr(g, m_ptr);
        bus.req_valid = '0;
        tick();
        tests++;
        if ({bus.req_ready, bus.cs_n} !== 5'b0000_0) begin
            fails++; $display("FAIL single_latency: got ready=%b cs_n=%b want 0000 0", bus.req_ready, bus.cs_n);
        end
        wait_fd(fd0 + 1, 200, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL single_fd_timeout: got %0d want %0d", fd_cnt, fd0 + 1); return; end
        tests++;
        if (bus.da_clr !== 1'b0) begin fails++; $display("FAIL single_da_clr: got %b want 0", bus.da_clr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (bus.cs_n !== 1'b1) begin fails++; $display("FAIL single_gap%0d: got cs_n=%b want 1", i, bus.cs_n); end
        end
        tests++;
        if (frm_q.size() != 1 || frm_q[0] !== 24'h32A5C3 || nbits != 24) begin
            fails++; $display("FAIL single_frame: got %h/%0d bits want 32a5c3/24", frm_q.size() ? frm_q[0] : 24'h0, nbits);
        end
        tests++;
        if (low_q.size() != 1 || low_q[0] != 97) begin
            fails++; $display("FAIL single_cs_low: got %0d want 97", low_q.size() ? low_q[0] : -1);
        end
        tests++;
        if (fd_cnt - fd0 != 1) begin fails++; $display("FAIL single_fd_count: got %0d want 1", fd_cnt - fd0); end
        wait_idle(20, ok);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int g, fd0;
        do_reset();
        for (int i = 0; i < 4; i++) dat[i] = 16'($urandom);
        set_data();
        fd0 = fd_cnt;
        bus.out_en = 1'b1; bus.req_valid = 4'b1111;
        wait_grants(6, 700, ok);
        bus.req_valid = '0;
        tests++;
        if (!ok) begin fails++; $display("FAIL b2b_timeout: got %0d want 6 grants", g_idx_q.size()); return; end
        wait_fd(fd0 + 6, 200, ok);
        wait_idle(20, ok);
        for (int i = 0; i < 6; i++) begin
            g = exp_grant(4'b1111, m_ptr);
            m_ptr = exp_ptr(g, m_ptr);
            tests++;
            if (g_idx_q[i] != g) begin fails++; $display("FAIL b2b_grant%0d: got %0d want %0d", i, g_idx_q[i], g); end
            if (i > 0) begin
                tests++;
                if (g_cyc_q[i] - g_cyc_q[i-1] != 100) begin
                    fails++; $display("FAIL b2b_period%0d: got %0d want 100", i, g_cyc_q[i] - g_cyc_q[i-1]);
                end
            end
            tests++;
            if (frm_q.size() <= i || frm_q[i] !== exp_frame(g, dat[g])) begin
                fails++; $display("FAIL b2b_frame%0d: got %h want %h", i, frm_q.size() > i ? frm_q[i] : 24'h0, exp_frame(g, dat[g]));
            end
        end
    endtask

    task automatic test_out_en_drop();
        bit ok;
        int g, fd0, gn;
        do_reset();
        for (int i = 0; i < 4; i++) dat[i] = 16'($urandom);
        set_data();
        fd0 = fd_cnt;
        bus.out_en = 1'b1; bus.req_valid = 4'b0010;
        wait_grants(1, 10, ok);
        g = exp_grant(4'b0010, m_ptr);
        m_ptr = exp_ptr(g, m_ptr);
        bus.req_valid = '0;
        wait_bits(10, 100, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL drop_bit10_timeout: got %0d bits want 10", nbits); return; end
        bus.out_en = 1'b0; bus.req_valid = 4'b1111;
        gn = g_idx_q.size();
        wait_fd(fd0 + 1, 200, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL drop_fd_timeout: got %0d want %0d", fd_cnt, fd0 + 1); return; end
        tick();
        tests++;
        if (frm_q.size() != 1 || frm_q[0] !== exp_frame(g, dat[g]) || nbits != 24) begin
            fails++; $display("FAIL drop_frame: got %h/%0d bits want %h/24", frm_q.size() ? frm_q[0] : 24'h0, nbits, exp_frame(g, dat[g]));
        end
        wait_idle(20, ok);
        tests++;
        if (!ok || bus.da_clr !== 1'b1) begin fails++; $display("FAIL drop_da_clr: got busy=%b da_clr=%b want 0 1", bus.busy, bus.da_clr); end
        repeat (250) tick();
        tests++;
        if (g_idx_q.size() != gn) begin fails++; $display("FAIL drop_no_grant: got %0d grants want %0d", g_idx_q.size(), gn); end
        bus.out_en = 1'b1;
        wait_grants(gn + 1, 10, ok);
        bus.req_valid = '0;
        g = exp_grant(4'b1111, m_ptr);
        m_ptr = exp_ptr(g, m_ptr);
        tests++;
        if (!ok || g_idx_q[gn] != g) begin fails++; $display("FAIL drop_ptr_kept: got %0d want %0d", ok ? g_idx_q[gn] : -1, g); end
        wait_fd(fd0 + 2, 200, ok);
        wait_idle(20, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int fd0, g;
        do_reset();
        for (int i = 0; i < 4; i++) dat[i] = 16'($urandom);
        dat[1][15] = 1'b1;
        set_data();
        bus.out_en = 1'b1; bus.req_valid = 4'b0010;
        wait_grants(1, 10, ok);
        bus.req_valid = '0;
        wait_bits(12, 100, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rstmid_bit12_timeout: got %0d bits want 12", nbits); return; end
        fd0 = fd_cnt;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.cs_n, bus.sclk, bus.dout, bus.busy, bus.req_ready} !== 8'b1000_0000) begin
            fails++; $display("FAIL rstmid_pins: got cs_n/sclk/dout/busy/ready=%b want 10000000",
                {bus.cs_n, bus.sclk, bus.dout, bus.busy, bus.req_ready});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        m_ptr = 0;
        g_idx_q.delete(); g_cyc_q.delete();
        repeat (5) tick();
        tests++;
        if (fd_cnt != fd0) begin fails++; $display("FAIL rstmid_no_fd: got %0d pulses want 0", fd_cnt - fd0); end
        bus.req_valid = 4'b1001;
        wait_grants(1, 10, ok);
        bus.req_valid = '0;
        g = exp_grant(4'b1001, m_ptr);
        m_ptr = exp_ptr(g, m_ptr);
        tests++;
        if (!ok || g_idx_q[0] != g) begin fails++; $display("FAIL rstmid_first_grant: got %0d want %0d", ok ? g_idx_q[0] : -1, g); end
        wait_fd(fd0 + 1, 200, ok);
        wait_idle(20, ok);
    endtask

    task automatic test_prio();
        bit ok;
        int g, fd0;
        do_reset();
        for (int i = 0; i < 4; i++) dat[i] = 16'($urandom);
        set_data();
        fd0 = fd_cnt;
        bus.out_en = 1'b1; bus.req_valid = 4'b1001;
        wait_grants(4, 450, ok);
        bus.req_valid = '0;
        tests++;
        if (!ok) begin fails++; $display("FAIL prio_timeout: got %0d want 4 grants", g_idx_q.size()); return; end
        for (int i = 0; i < 4; i++) begin
            g = exp_grant(4'b1001, m_ptr);
            m_ptr = exp_ptr(g, m_ptr);
            tests++;
            if (g_idx_q[i] != g) begin fails++; $display("FAIL prio_grant%0d: got %0d want %0d", i, g_idx_q[i], g); end
        end
        wait_fd(fd0 + 4, 200, ok);
        wait_idle(20, ok);
    endtask

    task automatic test_random();
        bit ok;
        int g, n0, f0;
        logic [3:0] mask;
        do_reset();
        bus.out_en = 1'b1;
        for (int it = 0; it < 8; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) dat[i] = 16'($urandom);
            set_data();
            n0 = g_idx_q.size();
            f0 = fd_cnt;
            bus.req_valid = mask;
            wait_grants(n0 + 1, 10, ok);
            bus.req_valid = '0;
            g = exp_grant(mask, m_ptr);
            m_ptr = exp_ptr(g, m_ptr);
            tests++;
            if (!ok || g_idx_q[n0] != g) begin
                fails++; $display("FAIL rand%0d_grant mask=%b: got %0d want %0d", it, mask, ok ? g_idx_q[n0] : -1, g);
                return;
            end
            wait_fd(f0 + 1, 200, ok);
            tick();
            tests++;
            if (!ok || frm_q[$] !== exp_frame(g, dat[g]) || low_q[$] != 97) begin
                fails++; $display("FAIL rand%0d_frame: got %h low=%0d want %h low=97", it,
                    frm_q.size() ? frm_q[$] : 24'h0, low_q.size() ? low_q[$] : -1, exp_frame(g, dat[g]));
            end
            wait_idle(20, ok);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_fast();
        bit ok;
        do_reset();
        fbus.req_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        fbus.out_en = 1'b1; fbus.req_valid = 4'b0001;
        wait_fgrants(2, 120, ok);
        fbus.req_valid = '0;
        tests++;
        if (!ok) begin fails++; $display("FAIL fast_timeout: got %0d want 2 grants", fg_cyc_q.size()); return; end
        tests++;
        if (fg_cyc_q[1] - fg_cyc_q[0] != 51) begin
            fails++; $display("FAIL fast_period: got %0d want 51", fg_cyc_q[1] - fg_cyc_q[0]);
        end
        tests++;
        if (f_low_q.size() < 1 || f_low_q[0] != 49) begin
            fails++; $display("FAIL fast_cs_low: got %0d want 49", f_low_q.size() ? f_low_q[0] : -1);
        end
        tests++;
        if (f_nr_q.size() < 1 || f_nr_q[0] != 24 || f_span_q[0] != 46) begin
            fails++; $display("FAIL fast_sclk: got rises=%0d span=%0d want 24 46",
                f_nr_q.size() ? f_nr_q[0] : -1, f_span_q.size() ? f_span_q[0] : -1);
        end
        repeat (60) tick();
        fbus.out_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prev_cs = 1'b1; prev_sclk = 1'b0; low_run = 0; nbits = 0; fd_cnt = 0; shbits = '0;
        f_prev_cs = 1'b1; f_prev_sclk = 1'b0; f_low_run = 0; f_nr = 0; f_first = 0; f_last = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_out_en_drop();
        test_reset_mid();
        test_prio();
        test_random();
        test_fast();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
